// File: rtl/mult_sched.sv
// mult_sched: round-robin scheduler that shares one DW-bit multiplier among NREQ requesters.
// Optional handshake watchdog (o_err) is built when MULT_SCHED_TIMEOUT_EN is defined.
//   state | meaning
//   IDLE  | no work; waiting for any request
//   GRANT | round-robin pick, capture winner's operands
//   ISSUE | one-cycle start pulse to the multiplier
//   WAIT  | waiting for a fresh rising edge on i_ms_stop
//   RESP  | done pulse to the winner, rotate priority
module mult_sched #(
    parameter int DW   = 8,
    parameter int NREQ = 4,
    parameter int TMO  = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NREQ-1:0]      i_req,
    input  logic [NREQ*DW-1:0]   i_multd,
    input  logic [NREQ*DW-1:0]   i_multr,
    output logic [NREQ-1:0]      o_gnt,
    output logic [NREQ-1:0]      o_done,
    output logic [2*DW:0]        o_result,
    output logic                 o_busy,
    output logic                 o_ms_start,
    output logic [DW-1:0]        o_ms_multd,
    output logic [DW-1:0]        o_ms_multr,
    input  logic [2*DW:0]        i_ms_rc,
    input  logic                 i_ms_stop
`ifdef MULT_SCHED_TIMEOUT_EN
    ,
    output logic                 o_err
`endif
);
    localparam int IW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TMO < 1) begin : g_bad_param
        $error("mult_sched: NREQ must be 2..8 and TMO at least 1");
    end

    typedef enum logic [2:0] {IDLE, GRANT, ISSUE, WAIT, RESP} state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  last_q, last_d;
    logic [IW-1:0]  win_q, win_d;
    logic [IW-1:0]  pick;
    logic           found;
    int             j;
    logic [DW-1:0]  multd_q, multd_d;
    logic [DW-1:0]  multr_q, multr_d;
    logic [2*DW:0]  result_q, result_d;
    logic           stop_q;
    logic           stop_rise;
`ifdef MULT_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TMO + 1);
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           err_q, err_d;
`endif

    // A stop level left over from the previous operation must not complete this one.
    assign stop_rise = i_ms_stop & ~stop_q;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        j     = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(last_q) + 1 + i;
            if (j >= NREQ) j = j - NREQ;
            if (!found && i_req[IW'(j)]) begin
                found = 1'b1;
                pick  = IW'(j);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        win_d      = win_q;
        multd_d    = multd_q;
        multr_d    = multr_q;
        result_d   = result_q;
        o_gnt      = '0;
        o_done     = '0;
        o_ms_start = 1'b0;
`ifdef MULT_SCHED_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (|i_req) state_d = GRANT;
            end
            GRANT: begin
                if (found) begin
                    o_gnt[pick] = 1'b1;
                    win_d       = pick;
                    multd_d     = i_multd[int'(pick)*DW +: DW];
                    multr_d     = i_multr[int'(pick)*DW +: DW];
                    state_d     = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                o_ms_start = 1'b1;
                state_d    = WAIT;
`ifdef MULT_SCHED_TIMEOUT_EN
                cnt_d      = '0;
`endif
            end
            WAIT: begin
                if (stop_rise) begin
                    result_d = i_ms_rc;
                    state_d  = RESP;
                end
`ifdef MULT_SCHED_TIMEOUT_EN
                else if (cnt_q == CW'(TMO - 1)) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            RESP: begin
                o_done[win_q] = 1'b1;
                last_d        = win_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= IDLE;
            last_q   <= IW'(NREQ - 1);
            win_q    <= '0;
            multd_q  <= '0;
            multr_q  <= '0;
            result_q <= '0;
            stop_q   <= 1'b0;
`ifdef MULT_SCHED_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            win_q    <= win_d;
            multd_q  <= multd_d;
            multr_q  <= multr_d;
            result_q <= result_d;
            stop_q   <= i_ms_stop;
`ifdef MULT_SCHED_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    assign o_busy     = (state_q != IDLE);
    assign o_result   = result_q;
    assign o_ms_multd = multd_q;
    assign o_ms_multr = multr_q;
`ifdef MULT_SCHED_TIMEOUT_EN
    assign o_err      = err_q;
`endif

endmodule

// File: doc/mult_sched.md
MULT_SCHED -- requirements
Module: mult_sched

Interface
REQ-001 Parameter DW, default 8: operand width, equal to the shared multiplier's width.
REQ-002 Parameter NREQ, default 4: number of requesters (2..8).
REQ-003 Parameter TMO, default 64: watchdog limit in cycles; used only when MULT_SCHED_TIMEOUT_EN is defined.
REQ-004 i_clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 i_rst  in  1  asynchronous, active-low reset.
REQ-006 i_req  in  NREQ  per-requester request level; held high until that requester's o_done pulse.
REQ-007 i_multd  in  NREQ*DW  packed multiplicands; slice k belongs to requester k.
REQ-008 i_multr  in  NREQ*DW  packed multipliers; slice k belongs to requester k.
REQ-009 o_gnt  out  NREQ  one-hot; high for the single cycle in which the operands are captured.
REQ-010 o_done  out  NREQ  one-hot one-cycle pulse; the result for that requester is valid.
REQ-011 o_result  out  2*DW+1  latched product; held until the next o_done.
REQ-012 o_busy  out  1  high in every state except IDLE.
REQ-013 o_ms_start  out  1  one-cycle start pulse to the multiplier.
REQ-014 o_ms_multd, o_ms_multr  out  DW each  registered operands to the multiplier; stable from the ISSUE state through the end of the operation.
REQ-015 i_ms_rc  in  2*DW+1  multiplier product.
REQ-016 i_ms_stop  in  1  multiplier completion level.
REQ-017 o_err  out  1  timeout flag; exists only when MULT_SCHED_TIMEOUT_EN is defined.

Function
REQ-018 FSM states are IDLE, GRANT, ISSUE, WAIT and RESP; transitions occur on i_clk edges only.
REQ-019 IDLE -> GRANT when |i_req is high; otherwise the FSM stays in IDLE.
REQ-020 GRANT: select the winner round-robin, searching from index (last+1) mod NREQ upward.
- Drive o_gnt for one cycle.
- Latch the winner's operand slices into o_ms_multd/o_ms_multr.
- Latch the winner index.
- Go to ISSUE.
REQ-021 ISSUE: o_ms_start=1 for exactly one cycle, then go to WAIT.
REQ-022 WAIT: complete on a rising edge of i_ms_stop, i.e. i_ms_stop=1 this cycle and 0 in the registered previous sample.
- On completion: capture i_ms_rc into o_result and go to RESP.
- A stop level still high from a prior operation does not complete the operation.
REQ-023 RESP: o_done[winner]=1 for one cycle, update last=winner, and go to IDLE.
REQ-024 Minimum turnaround from request to done = 4 cycles plus the multiplier latency; back-to-back grants are separated by at least one IDLE cycle.
REQ-025 A requester that drops i_req after its grant still receives o_done; the scheduler never cancels an issued operation.
REQ-026 Requests rising during GRANT through RESP are not granted until the FSM returns to IDLE.
REQ-027 Simultaneous requests: exactly one grant per arbitration; no requester waits more than NREQ-1 other grants (starvation-free).
REQ-028 Operand changes on i_multd/i_multr after the grant cycle have no effect on the operation in flight.
REQ-029 o_result width is 2*DW+1; the product is passed through unmodified, with no truncation or sign handling.

Reset
REQ-030 While i_rst=0, asynchronously force:
- FSM=IDLE, last=NREQ-1 so that requester 0 has first priority.
- o_gnt=0, o_done=0, o_result=0, o_busy=0, o_ms_start=0, o_ms_multd=0, o_ms_multr=0, o_err=0.
- Stop history register=0.
REQ-031 Reset asserted mid-operation abandons the operation without o_done; after release, the bench must also reset the multiplier before issuing new work.

Configuration
REQ-032 Macro MULT_SCHED_TIMEOUT_EN, when defined:
- A counter clears on entry to WAIT and increments each WAIT cycle.
- On reaching TMO cycles without completion: set o_err (sticky until reset), pulse o_done[winner] with o_result=0, and go to IDLE.
REQ-033 With MULT_SCHED_TIMEOUT_EN undefined:
- No counter and no o_err port are built.
- WAIT persists indefinitely until completion.

Verification
REQ-034 Single request: i_req=0001, multd=13, multr=11 -> o_gnt=0001, one o_ms_start pulse, o_done=0001, o_result=143.
REQ-035 All requesters: i_req=1111 held -> grant order 0,1,2,3,0; each o_done matches its own operands (e.g. 255*255=65025 on slot 3).
REQ-036 Mid-flight change: operands of the granted requester changed in the WAIT state -> o_result reflects the operands captured at grant.
REQ-037 Stale stop: i_ms_stop held high entering WAIT -> no completion until stop falls and rises again.
REQ-038 Reset abort: i_rst pulsed low during WAIT -> all outputs 0 immediately, no o_done, next grant goes to requester 0.
REQ-039 With MULT_SCHED_TIMEOUT_EN, TMO=64 and i_ms_stop tied 0 -> o_err=1 and o_done pulses with o_result=0 after 64 WAIT cycles.
